gemm_operand_loader: RTL and testbench

GEMM_OPERAND_LOADER -- requirements
Module: gemm_operand_loader

---
 rtl/gemm_pkg.sv | 21 ++
 rtl/gemm_operand_loader_if.sv | 36 +++
 rtl/gemm_operand_loader.sv | 172 +++++++++++++++++
 tb/tb_gemm_operand_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM operand loader.
//   loader_state_e : loader FSM encoding (IDLE -> LOAD -> DONE -> IDLE)
//   size_is_legal  : a dimension is usable when non-zero and a whole number of tiles
//   tile_count     : number of tiles along a dimension
package gemm_pkg;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } loader_state_e;

    function automatic logic size_is_legal(input int unsigned size, input int unsigned per);
        return (size != 32'd0) && (per != 32'd0) && ((size % per) == 32'd0);
    endfunction

    function automatic int unsigned tile_count(input int unsigned size, input int unsigned per);
        return (per == 32'd0) ? 32'd0 : size / per;
    endfunction

endpackage

// File: rtl/gemm_operand_loader_if.sv
// Stream-in / SRAM-write bundle of the GEMM operand loader.
//   s_data_i/s_valid_i/s_ready_o : tile-row beat stream into the loader
//   sram_addr_o/sram_we_o/sram_wdata_o : SRAM write port driven by the loader
// Modports: slave = loader side, master = producer/SRAM side.
interface gemm_operand_loader_if #(
    parameter int unsigned BeatWidth  = 32,
    parameter int unsigned AddrWidth  = 12,
    parameter int unsigned InMemWidth = 128
);

    logic [BeatWidth-1:0]  s_data_i;
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [AddrWidth-1:0]  sram_addr_o;
    logic                  sram_we_o;
    logic [InMemWidth-1:0] sram_wdata_o;

    modport slave (
        input  s_data_i,
        input  s_valid_i,
        output s_ready_o,
        output sram_addr_o,
        output sram_we_o,
        output sram_wdata_o
    );

    modport master (
        output s_data_i,
        output s_valid_i,
        input  s_ready_o,
        input  sram_addr_o,
        input  sram_we_o,
        input  sram_wdata_o
    );

endinterface

// File: rtl/gemm_operand_loader.sv
// GEMM operand loader: accepts tile-row beats (order rt, kt, r_in) and packs
// NumPE beats into one SRAM word per tile, writing tile w = rt*Kt + kt to
// base_addr + w (wrapping modulo 2^AddrWidth).
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i                : single-cycle load request (only honoured in IDLE)
//   rows_size_i, K_size_i  : matrix rows (M or N) and K dimension
//   base_addr_i            : SRAM word address of the first tile
//   bus (slave)            : beat stream in, SRAM write port out
//   busy_o, done_o, err_o  : load in progress, completion pulse, illegal-size flag
module gemm_operand_loader
    import gemm_pkg::*;
#(
    parameter int unsigned InDataWidth   = 8,
    parameter int unsigned NumPE         = 4,
    parameter int unsigned NumIp_K       = 4,
    parameter int unsigned InMemWidth    = InDataWidth * NumPE * NumIp_K,
    parameter int unsigned AddrWidth     = 12,
    parameter int unsigned SizeAddrWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] rows_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [AddrWidth-1:0]     base_addr_i,
    gemm_operand_loader_if.slave     bus,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int unsigned BeatWidth = NumIp_K * InDataWidth;
    localparam int unsigned RinWidth  = (NumPE > 1) ? $clog2(NumPE) : 1;

    loader_state_e              state_q, state_d;
    logic [SizeAddrWidth-1:0]   rt_tiles_q, rt_tiles_d;
    logic [SizeAddrWidth-1:0]   kt_tiles_q, kt_tiles_d;
    logic [SizeAddrWidth-1:0]   rt_cnt_q, rt_cnt_d;
    logic [SizeAddrWidth-1:0]   kt_cnt_q, kt_cnt_d;
    logic [RinWidth-1:0]        rin_q, rin_d;
    logic [AddrWidth-1:0]       addr_q, addr_d;
    logic [InMemWidth-1:0]      acc_q, acc_d;
    logic                       we_q, we_d;
    logic                       beats_done_q, beats_done_d;
    logic                       err_q, err_d;

    logic s_ready;
    logic beat_fire;
    logic rin_last, kt_last, rt_last;
    logic rows_ok, k_ok;

    // Ready is purely a function of state, never of s_valid_i.
    assign s_ready   = (state_q == LD_LOAD) && !beats_done_q;
    assign beat_fire = s_ready && bus.s_valid_i;

    assign rin_last = (rin_q == RinWidth'(NumPE - 1));
    assign kt_last  = (kt_cnt_q == (kt_tiles_q - SizeAddrWidth'(1)));
    assign rt_last  = (rt_cnt_q == (rt_tiles_q - SizeAddrWidth'(1)));

    assign rows_ok = size_is_legal(32'(rows_size_i), NumPE);
    assign k_ok    = size_is_legal(32'(K_size_i), NumIp_K);

    always_comb begin
        state_d      = state_q;
        rt_tiles_d   = rt_tiles_q;
        kt_tiles_d   = kt_tiles_q;
        rt_cnt_d     = rt_cnt_q;
        kt_cnt_d     = kt_cnt_q;
        rin_d        = rin_q;
        acc_d        = acc_q;
        we_d         = 1'b0;
        beats_done_d = beats_done_q;
        err_d        = err_q;
        // The address advances after each write, so it always points at the
        // next tile's slot without a multiplier.
        addr_d       = we_q ? (addr_q + AddrWidth'(1)) : addr_q;

        unique case (state_q)
            LD_IDLE: begin
                if (start_i) begin
                    err_d        = !(rows_ok && k_ok);
                    rt_tiles_d   = SizeAddrWidth'(tile_count(32'(rows_size_i), NumPE));
                    kt_tiles_d   = SizeAddrWidth'(tile_count(32'(K_size_i), NumIp_K));
                    rt_cnt_d     = '0;
                    kt_cnt_d     = '0;
                    rin_d        = '0;
                    beats_done_d = 1'b0;
                    addr_d       = base_addr_i;
                    state_d      = (rows_ok && k_ok) ? LD_LOAD : LD_DONE;
                end
            end

            LD_LOAD: begin
                if (beat_fire) begin
                    for (int unsigned r = 0; r < NumPE; r++) begin
                        if (rin_q == RinWidth'(r)) begin
                            acc_d[r*BeatWidth +: BeatWidth] = bus.s_data_i;
                        end
                    end
                    if (rin_last) begin
                        // Word is complete: it is presented from acc_q next
                        // cycle while beat 0 of the next tile overwrites slot 0.
                        rin_d = '0;
                        we_d  = 1'b1;
                        if (kt_last) begin
                            kt_cnt_d = '0;
                            if (rt_last) begin
                                beats_done_d = 1'b1;
                            end else begin
                                rt_cnt_d = rt_cnt_q + SizeAddrWidth'(1);
                            end
                        end else begin
                            kt_cnt_d = kt_cnt_q + SizeAddrWidth'(1);
                        end
                    end else begin
                        rin_d = rin_q + RinWidth'(1);
                    end
                end
                if (we_q && beats_done_q) begin
                    state_d = LD_DONE;
                end
            end

            LD_DONE: begin
                state_d = LD_IDLE;
            end

            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= LD_IDLE;
            rt_tiles_q   <= '0;
            kt_tiles_q   <= '0;
            rt_cnt_q     <= '0;
            kt_cnt_q     <= '0;
            rin_q        <= '0;
            addr_q       <= '0;
            acc_q        <= '0;
            we_q         <= 1'b0;
            beats_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rt_tiles_q   <= rt_tiles_d;
            kt_tiles_q   <= kt_tiles_d;
            rt_cnt_q     <= rt_cnt_d;
            kt_cnt_q     <= kt_cnt_d;
            rin_q        <= rin_d;
            addr_q       <= addr_d;
            acc_q        <= acc_d;
            we_q         <= we_d;
            beats_done_q <= beats_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.s_ready_o    = s_ready;
    assign bus.sram_we_o    = we_q;
    assign bus.sram_addr_o  = addr_q;
    assign bus.sram_wdata_o = acc_q;

    assign busy_o = (state_q != LD_IDLE);
    assign done_o = (state_q == LD_DONE);
    assign err_o  = err_q;

endmodule

// File: tb/tb_gemm_operand_loader.sv
// Directed bench for gemm_operand_loader (default parameters).
module tb_gemm_operand_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  rows_size;
    logic [7:0]  k_size;
    logic [11:0] base_addr;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [11:0]  wr_addr[$];
    logic [127:0] wr_data[$];
    int           wr_cyc[$];
    int           done_cyc[$];
    int           ready_cnt;

    gemm_operand_loader_if #(.BeatWidth(32), .AddrWidth(12), .InMemWidth(128)) bus ();

    gemm_operand_loader #(
        .InDataWidth(8), .NumPE(4), .NumIp_K(4), .InMemWidth(128),
        .AddrWidth(12), .SizeAddrWidth(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .rows_size_i(rows_size), .K_size_i(k_size), .base_addr_i(base_addr),
        .bus(bus), .busy_o(busy), .done_o(done), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.sram_we_o === 1'b1) begin
            wr_addr.push_back(bus.sram_addr_o);
            wr_data.push_back(bus.sram_wdata_o);
            wr_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
        if (bus.s_ready_o === 1'b1) ready_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    // Beat b: element k = (4*b + k) ^ (b >> 6), element k at bits k*8.
    function automatic logic [31:0] beat_val(input int b);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'((4*b + k) ^ (b >> 6));
        return v;
    endfunction

    // Word w packs beats 4w..4w+3, beat r at bits r*32.
    function automatic logic [127:0] exp_word(input int w);
        logic [127:0] e;
        for (int r = 0; r < 4; r++) e[r*32 +: 32] = beat_val(4*w + r);
        return e;
    endfunction

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc.delete();
        ready_cnt = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the pulse.
    task automatic do_start(input logic [7:0] rows, input logic [7:0] ks,
                            input logic [11:0] base, output int s);
        rows_size = rows;
        k_size    = ks;
        base_addr = base;
        start     = 1'b1;
        s         = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic feed(input int nbeats, input bit gaps, input int start_at,
                        output int stalls, output bit ok);
        int  idx;
        int  iter;
        bit  v;
        bit  r;
        idx    = 0;
        iter   = 0;
        stalls = 0;
        while (idx < nbeats && iter < 2000) begin
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.s_valid_i = v;
            bus.s_data_i  = v ? beat_val(idx) : 32'hDEAD_BEEF;
            start = (iter == start_at);
            r = bus.s_ready_o;
            @(posedge clk); #1;
            if (v && r) idx++;
            else if (v && !r) stalls++;
            iter++;
        end
        start         = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 32'h0BAD_F00D;
        ok = (idx == nbeats);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rows_size = '0; k_size = '0; base_addr = '0;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.s_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", bus.s_ready_o); end
        checks++; if (bus.sram_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", bus.sram_we_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int s, stalls, n;
        bit ok, dok;
        clear_mon();
        do_start(8'd4, 8'd64, 12'd0, s);
        feed(64, 1'b0, -1, stalls, ok);
        wait_done(200, dok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_feed: got incomplete required 64 beats"); end
        checks++; if (!dok) begin errors++; $display("FAIL b2b_done_timeout: got no done required done"); end
        checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_stalls: got %0d required 0", stalls); end
        checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL b2b_write_count: got %0d required 16", wr_addr.size()); end
        n = (wr_addr.size() < 16) ? wr_addr.size() : 16;
        for (int i = 0; i < n; i++) begin
            checks++; if (wr_addr[i] !== 12'(i)) begin errors++; $display("FAIL b2b_addr[%0d]: got %0d required %0d", i, wr_addr[i], i); end
            checks++; if (wr_data[i] !== exp_word(i)) begin errors++; $display("FAIL b2b_data[%0d]: got %h required %h", i, wr_data[i], exp_word(i)); end
        end
        if (n == 16) begin
            checks++; if (wr_data[0] !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin errors++; $display("FAIL b2b_word0: got %h required 0f0e..0100", wr_data[0]); end
            checks++; if (wr_data[1] !== 128'h1F1E1D1C_1B1A1918_17161514_13121110) begin errors++; $display("FAIL b2b_word1: got %h required 1f1e..1110", wr_data[1]); end
            checks++; if (wr_data[15] !== 128'hFFFEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0) begin errors++; $display("FAIL b2b_word15: got %h required fffe..f1f0", wr_data[15]); end
            checks++; if (wr_cyc[0] != s + 5) begin errors++; $display("FAIL b2b_first_write_cycle: got %0d required %0d", wr_cyc[0], s + 5); end
            checks++; if (wr_cyc[15] != s + 65) begin errors++; $display("FAIL b2b_last_write_cycle: got %0d required %0d", wr_cyc[15], s + 65); end
        end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d required 1", done_cyc.size()); end
        if (done_cyc.size() > 0) begin
            checks++; if (done_cyc[0] != s + 66) begin errors++; $display("FAIL b2b_done_cycle: got %0d required %0d", done_cyc[0], s + 66); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after: got %b required 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b required 0", err); end
    endtask

    task automatic test_gaps();
        int s, stalls, n;
        bit ok, dok;
        clear_mon();
        do_start(8'd16, 8'd64, 12'd0, s);
        feed(256, 1'b1, -1, stalls, ok);
        wait_done(200, dok);
        checks++; if (!ok) begin errors++; $display("FAIL gap_feed: got incomplete required 256 beats"); end
        checks++; if (!dok) begin errors++; $display("FAIL gap_done_timeout: got no done required done"); end
        checks++; if (wr_addr.size() != 64) begin errors++; $display("FAIL gap_write_count: got %0d required 64", wr_addr.size()); end
        n = (wr_addr.size() < 64) ? wr_addr.size() : 64;
        for (int i = 0; i < n; i++) begin
            checks++; if (wr_addr[i] !== 12'(i)) begin errors++; $display("FAIL gap_addr[%0d]: got %0d required %0d", i, wr_addr[i], i); end
            checks++; if (wr_data[i] !== exp_word(i)) begin errors++; $display("FAIL gap_data[%0d]: got %h required %h", i, wr_data[i], exp_word(i)); end
        end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL gap_done_pulses: got %0d required 1", done_cyc.size()); end
    endtask

    task automatic test_illegal();
        int s;
        bit dok;
        clear_mon();
        do_start(8'd6, 8'd64, 12'd0, s);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err_rows6: got %b required 1", err); end
        wait_done(20, dok);
        checks++; if (!dok) begin errors++; $display("FAIL ill_done_timeout: got no done required done"); end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL ill_done_pulses: got %0d required 1", done_cyc.size()); end
        if (done_cyc.size() > 0) begin
            checks++; if (done_cyc[0] != s + 1) begin errors++; $display("FAIL ill_done_cycle: got %0d required %0d", done_cyc[0], s + 1); end
        end
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL ill_writes: got %0d required 0", wr_addr.size()); end
        checks++; if (ready_cnt != 0) begin errors++; $display("FAIL ill_ready_cycles: got %0d required 0", ready_cnt); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err_hold: got %b required 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ill_busy_after: got %b required 0", busy); end

        clear_mon();
        do_start(8'd0, 8'd16, 12'd0, s);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err_rows0: got %b required 1", err); end
        wait_done(20, dok);
        do_start(8'd8, 8'd62, 12'd0, s);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err_k62: got %b required 1", err); end
        wait_done(20, dok);
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL ill_writes_more: got %0d required 0", wr_addr.size()); end
    endtask

    task automatic test_wrap();
        int s, stalls, n;
        bit ok, dok;
        logic [11:0] exp_a [4];
        exp_a = '{12'd4094, 12'd4095, 12'd0, 12'd1};
        clear_mon();
        do_start(8'd4, 8'd16, 12'd4094, s);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err_cleared: got %b required 0", err); end
        feed(16, 1'b0, -1, stalls, ok);
        wait_done(50, dok);
        checks++; if (!dok) begin errors++; $display("FAIL wrap_done_timeout: got no done required done"); end
        checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL wrap_write_count: got %0d required 4", wr_addr.size()); end
        n = (wr_addr.size() < 4) ? wr_addr.size() : 4;
        for (int i = 0; i < n; i++) begin
            checks++; if (wr_addr[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d required %0d", i, wr_addr[i], exp_a[i]); end
            checks++; if (wr_data[i] !== exp_word(i)) begin errors++; $display("FAIL wrap_data[%0d]: got %h required %h", i, wr_data[i], exp_word(i)); end
        end
    endtask

    task automatic test_start_ignored();
        int s, stalls, n;
        bit ok, dok;
        clear_mon();
        do_start(8'd4, 8'd16, 12'd100, s);
        rows_size = 8'd8;
        k_size    = 8'd64;
        base_addr = 12'd0;
        feed(16, 1'b0, 5, stalls, ok);
        wait_done(50, dok);
        checks++; if (!dok) begin errors++; $display("FAIL ign_done_timeout: got no done required done"); end
        checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL ign_write_count: got %0d required 4", wr_addr.size()); end
        n = (wr_addr.size() < 4) ? wr_addr.size() : 4;
        for (int i = 0; i < n; i++) begin
            checks++; if (wr_addr[i] !== 12'(100 + i)) begin errors++; $display("FAIL ign_addr[%0d]: got %0d required %0d", i, wr_addr[i], 100 + i); end
            checks++; if (wr_data[i] !== exp_word(i)) begin errors++; $display("FAIL ign_data[%0d]: got %h required %h", i, wr_data[i], exp_word(i)); end
        end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL ign_done_pulses: got %0d required 1", done_cyc.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_reset_mid_load();
        int s, stalls;
        bit ok, dok;
        clear_mon();
        do_start(8'd4, 8'd16, 12'd200, s);
        feed(2, 1'b0, -1, stalls, ok);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
        checks++; if (bus.s_ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b required 0", bus.s_ready_o); end
        checks++; if (bus.sram_we_o !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %b required 0", bus.sram_we_o); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b required 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b required 0", err); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL rst_mid_writes: got %0d required 0", wr_addr.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b required 0", busy); end

        clear_mon();
        do_start(8'd4, 8'd4, 12'd7, s);
        feed(4, 1'b0, -1, stalls, ok);
        wait_done(20, dok);
        checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL rst_fresh_count: got %0d required 1", wr_addr.size()); end
        if (wr_addr.size() == 1) begin
            checks++; if (wr_addr[0] !== 12'd7) begin errors++; $display("FAIL rst_fresh_addr: got %0d required 7", wr_addr[0]); end
            checks++; if (wr_data[0] !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin errors++; $display("FAIL rst_fresh_data: got %h required 0f0e..0100", wr_data[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_illegal();
        test_wrap();
        test_start_ignored();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
